pf_issue_queue: RTL and testbench

//  Buffers prefetch candidates produced by the isb prefetcher (pf_v/pf_addr) and issues them
//  to the memory side over a valid/ready handshake. Drops duplicates already queued, drops

---
 rtl/pf_issue_queue.sv | 109 ++++++++++
 tb/tb_pf_issue_queue.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pf_issue_queue.sv
// Prefetch issue queue: buffers isb candidates, dedups, drops on overflow, cancels on demand hit.
// Optional statistics counters are enabled with `define PFQ_STATS_EN.
module pf_issue_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 16,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pf_v,
   input  logic [AW-1:0] pf_addr,
   input  logic          dmd_v,
   input  logic [AW-1:0] dmd_addr,
   output logic          mem_v,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_rdy,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
`ifdef PFQ_STATS_EN
   ,
   output logic [15:0]   stat_issued,
   output logic [15:0]   stat_dropped,
   output logic [15:0]   stat_cancelled
`endif
);

   logic [DEPTH-1:0] vld_q;
   logic [AW-1:0]    addr_q [DEPTH];
   logic [PW-1:0]    head_q, tail_q;
   logic [CW-1:0]    count_q;

   logic             pop, skip, push, dup, dmd_clash;
   logic [DEPTH-1:0] cancel_hit, cancel_eff;

   assign count = count_q;
   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));

   // Head entry drives the request port directly; a cancelled head shows mem_v=0 and is skipped.
   assign mem_v    = !empty && vld_q[head_q];
   assign mem_addr = empty ? '0 : addr_q[head_q];
   assign pop      = mem_v && mem_rdy;
   assign skip     = !empty && !vld_q[head_q];

   // NOTE: every variable assigned here gets a default first, otherwise a latch is inferred.
   always_comb begin
      dup        = 1'b0;
      cancel_hit = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i] && addr_q[i] == pf_addr)  dup           = 1'b1;
         if (dmd_v && vld_q[i] && addr_q[i] == dmd_addr) cancel_hit[i] = 1'b1;
      end
      // A head being handed over this cycle counts as issued, not cancelled.
      cancel_eff = cancel_hit;
      if (pop) cancel_eff[head_q] = 1'b0;
   end

   assign dmd_clash = dmd_v && (dmd_addr == pf_addr);
   assign push      = pf_v && !full && !dup && !dmd_clash;

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q   <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         vld_q <= vld_q & ~cancel_hit;
         if (pop || skip) begin
            vld_q[head_q] <= 1'b0;
            head_q        <= head_q + PW'(1);
         end
         if (push) begin
            vld_q[tail_q] <= 1'b1;
            tail_q        <= tail_q + PW'(1);
         end
         count_q <= count_q + CW'(push) - CW'(pop || skip);
      end
   end

   // NOTE: the address array is not reset; no slot is read as valid until written, and mem_addr is forced to 0 when empty.
   always_ff @(posedge clk) begin
      if (push) addr_q[tail_q] <= pf_addr;
   end

`ifdef PFQ_STATS_EN
   logic [15:0] issued_q, dropped_q, cancelled_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issued_q    <= '0;
         dropped_q   <= '0;
         cancelled_q <= '0;
      end else begin
         if (pop && issued_q != 16'hFFFF)              issued_q    <= issued_q + 16'd1;
         if (pf_v && !push && dropped_q != 16'hFFFF)   dropped_q   <= dropped_q + 16'd1;
         if (|cancel_eff && cancelled_q != 16'hFFFF)   cancelled_q <= cancelled_q + 16'd1;
      end
   end

   assign stat_issued    = issued_q;
   assign stat_dropped   = dropped_q;
   assign stat_cancelled = cancelled_q;
`endif

endmodule

// File: tb/tb_pf_issue_queue.sv
// Directed self-checking bench for pf_issue_queue (DEPTH=4, AW=16).
// Stats checks are compiled in when PFQ_STATS_EN is defined.
module tb_pf_issue_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 16;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          pf_v, dmd_v, mem_rdy;
   logic [AW-1:0] pf_addr, dmd_addr;
   logic          mem_v, full, empty;
   logic [AW-1:0] mem_addr;
   logic [CW-1:0] count;
`ifdef PFQ_STATS_EN
   logic [15:0]   stat_issued, stat_dropped, stat_cancelled;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   pf_issue_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .pf_v     (pf_v),
      .pf_addr  (pf_addr),
      .dmd_v    (dmd_v),
      .dmd_addr (dmd_addr),
      .mem_v    (mem_v),
      .mem_addr (mem_addr),
      .mem_rdy  (mem_rdy),
      .full     (full),
      .empty    (empty),
      .count    (count)
`ifdef PFQ_STATS_EN
      ,
      .stat_issued    (stat_issued),
      .stat_dropped   (stat_dropped),
      .stat_cancelled (stat_cancelled)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge; outputs are then sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pf_v = 1'b0; dmd_v = 1'b0; mem_rdy = 1'b0;
      pf_addr = '0; dmd_addr = '0;
   endtask

   task automatic push(input logic [AW-1:0] a);
      pf_v = 1'b1; pf_addr = a;
      tick();
      pf_v = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      #1;
   endtask

   initial begin
      do_reset();
      check("rst_count", 32'(count), 0);
      check("rst_empty", 32'(empty), 1);
      check("rst_full",  32'(full),  0);
      check("rst_mem_v", 32'(mem_v), 0);
      check("rst_addr",  32'(mem_addr), 0);

      // 1: fill with 0x10..0x13, mem_rdy low; 5th candidate dropped on full
      push(16'h0010);
      check("t1_lat_mem_v", 32'(mem_v), 1);
      check("t1_lat_addr",  32'(mem_addr), 32'h10);
      for (int i = 1; i < 4; i++) push(16'h0010 + 16'(i));
      check("t1_count", 32'(count), 4);
      check("t1_full",  32'(full),  1);
      check("t1_mem_v", 32'(mem_v), 1);
      check("t1_addr",  32'(mem_addr), 32'h10);
      push(16'h0014);
      check("t1_drop_count", 32'(count), 4);

      // 2: drain in order
      mem_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("t2_mem_v", 32'(mem_v), 1);
         check("t2_order", 32'(mem_addr), 32'h10 + 32'(i));
         tick();
      end
      mem_rdy = 1'b0;
      check("t2_empty", 32'(empty), 1);
      check("t2_mem_v_lo", 32'(mem_v), 0);
      check("t2_addr0", 32'(mem_addr), 0);

      // 4: cancel of head by demand, then skip
      push(16'h0020);
      push(16'h0021);
      check("t4_count2", 32'(count), 2);
      dmd_v = 1'b1; dmd_addr = 16'h0020;
      tick();
      dmd_v = 1'b0;
      check("t4_cancel_mem_v", 32'(mem_v), 0);
      check("t4_cancel_count", 32'(count), 2);
      tick();
      check("t4_skip_mem_v", 32'(mem_v), 1);
      check("t4_skip_addr",  32'(mem_addr), 32'h21);
      check("t4_skip_count", 32'(count), 1);
      mem_rdy = 1'b1;
      tick();
      mem_rdy = 1'b0;
      check("t4_empty", 32'(empty), 1);

`ifdef PFQ_STATS_EN
      check("stat_issued",    32'(stat_issued),    5);
      check("stat_dropped",   32'(stat_dropped),   1);
      check("stat_cancelled", 32'(stat_cancelled), 1);
`endif

      // 3: duplicate of a queued address is dropped
      push(16'h0020);
      push(16'h0020);
      check("t3_count", 32'(count), 1);
      mem_rdy = 1'b1;
      check("t3_addr", 32'(mem_addr), 32'h20);
      tick();
      check("t3_once_mem_v", 32'(mem_v), 0);
      check("t3_once_empty", 32'(empty), 1);
      mem_rdy = 1'b0;

      // Same-cycle demand to the candidate address drops the candidate
      pf_v = 1'b1; pf_addr = 16'h0050; dmd_v = 1'b1; dmd_addr = 16'h0050;
      tick();
      idle();
      check("dmd_clash_count", 32'(count), 0);

      // Push and pop together when not full: count unchanged
      push(16'h0060);
      pf_v = 1'b1; pf_addr = 16'h0061; mem_rdy = 1'b1;
      tick();
      idle();
      check("pushpop_count", 32'(count), 1);
      check("pushpop_addr",  32'(mem_addr), 32'h61);
      mem_rdy = 1'b1;
      tick();
      mem_rdy = 1'b0;
      check("pushpop_empty", 32'(empty), 1);

      // 5: full + pop + push same cycle -> pop happens, push dropped; then async reset
      for (int i = 0; i < 4; i++) push(16'h0040 + 16'(i));
      check("t5_full", 32'(full), 1);
      pf_v = 1'b1; pf_addr = 16'h0030; mem_rdy = 1'b1;
      tick();
      idle();
      check("t5_count", 32'(count), 3);
      check("t5_addr",  32'(mem_addr), 32'h41);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_mem_v", 32'(mem_v), 0);
      check("t5_rst_count", 32'(count), 0);
      check("t5_rst_empty", 32'(empty), 1);
      #3 rst_n = 1'b1;
      tick();
      check("t5_post_count", 32'(count), 0);
      // A previously queued address must not be treated as a duplicate after reset
      push(16'h0042);
      check("t5_post_push", 32'(count), 1);
      check("t5_post_addr", 32'(mem_addr), 32'h42);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
